// File: rtl/aes_key_bank.sv
// aes_key_bank: NUM_SLOTS-context AES-128/192/256 round-key store with a word-serial expander on a shared S-box.
// Latency: init to done 42/48/54 cycles, reads combinational; no backpressure, init while busy is dropped.
// Optional AES_KEY_BANK_ZEROIZE_EN: zeroize wipes every slot and aborts a running expansion.
module aes_key_bank #(
    parameter int NUM_SLOTS = 4,
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [255:0]         key,
    input  logic [1:0]           keylen,
    input  logic [SLOT_W-1:0]    slot_wr,
    input  logic                 init,
    input  logic [SLOT_W-1:0]    slot_rd,
    input  logic [3:0]           round,
    output logic [127:0]         round_key,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [NUM_SLOTS-1:0] slot_valid,
    input  logic                 zeroize,
    output logic [31:0]          sboxw,
    input  logic [31:0]          new_sboxw
);

    typedef enum logic [1:0] {IDLE, LOAD, GEN, DONE} state_t;

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            2'd1:    return 4'd6;
            2'd2:    return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            2'd1:    return 4'd12;
            2'd2:    return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] last_of(input logic [1:0] kl);
        case (kl)
            2'd1:    return 6'd51;
            2'd2:    return 6'd59;
            default: return 6'd43;
        endcase
    endfunction

    state_t               state_q, state_d;
    logic [255:0]         key_q;
    logic [1:0]           klen_q;
    logic [SLOT_W-1:0]    slot_q;
    logic [31:0]          win_q [8];
    logic [5:0]           widx_q;
    logic [2:0]           phase_q;
    logic [7:0]           rcon_q;
    logic [31:0]          mem [NUM_SLOTS][60];
    logic [1:0]           slot_klen [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] valid_q;

    logic                 zero_req;
    logic                 wr_in_range, init_ok;
    logic                 accept, reject, load_en, gen_en, fin_en;
    logic [3:0]           nk;
    logic [31:0]          kw [8];
    logic [31:0]          rot_w, temp, new_w;
    logic                 rd_in_range, rd_hit;
    logic [SLOT_W-1:0]    rd_slot;
    logic [5:0]           rd_base;

`ifdef AES_KEY_BANK_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    logic unused_zeroize;
    assign unused_zeroize = zeroize;
    assign zero_req       = 1'b0;
`endif

    assign wr_in_range = int'(slot_wr) < NUM_SLOTS;
    assign init_ok     = (keylen != 2'd3) && wr_in_range;
    assign slot_valid  = valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (init && init_ok) state_d = LOAD;
            LOAD:    state_d = GEN;
            GEN:     if (widx_q == last_of(klen_q)) state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (zero_req) state_d = IDLE;
    end

    always_comb begin
        accept  = (state_q == IDLE) && init && init_ok && !zero_req;
        reject  = (state_q == IDLE) && init && !init_ok && !zero_req;
        load_en = (state_q == LOAD);
        gen_en  = (state_q == GEN);
        fin_en  = (state_q == DONE);
    end

    always_comb begin
        for (int m = 0; m < 8; m++) kw[m] = key_q[255 - 32*m -: 32];
    end

    // Window index 0 holds w[i-1], index Nk-1 holds w[i-Nk]; phase tracks i mod Nk.
    always_comb begin
        nk    = nk_of(klen_q);
        sboxw = win_q[0];
        rot_w = {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_q, 24'h0};
        if (phase_q == 3'd0)                       temp = rot_w;
        else if (nk == 4'd8 && phase_q == 3'd4)    temp = new_sboxw;
        else                                       temp = win_q[0];
        new_w = win_q[3'(nk - 4'd1)] ^ temp;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q   <= '0;
            klen_q  <= '0;
            slot_q  <= '0;
            widx_q  <= '0;
            phase_q <= '0;
            rcon_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            valid_q <= '0;
            for (int j = 0; j < 8; j++) win_q[j] <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) slot_klen[s] <= '0;
        end else begin
            done <= fin_en && !zero_req;
            err  <= reject;
            if (zero_req) begin
                busy    <= 1'b0;
                valid_q <= '0;
                for (int s = 0; s < NUM_SLOTS; s++) slot_klen[s] <= '0;
            end else begin
                if (accept) begin
                    key_q            <= key;
                    klen_q           <= keylen;
                    slot_q           <= slot_wr;
                    valid_q[slot_wr] <= 1'b0;
                    busy             <= 1'b1;
                end
                if (load_en) begin
                    for (int j = 0; j < 8; j++)
                        win_q[j] <= (j < int'(nk)) ? kw[3'(int'(nk) - 1 - j)] : '0;
                    widx_q  <= {2'b00, nk};
                    phase_q <= 3'd0;
                    rcon_q  <= 8'h01;
                end
                if (gen_en) begin
                    for (int j = 7; j > 0; j--) win_q[j] <= win_q[j-1];
                    win_q[0] <= new_w;
                    widx_q   <= widx_q + 6'd1;
                    phase_q  <= ({1'b0, phase_q} == nk - 4'd1) ? 3'd0 : phase_q + 3'd1;
                    if (phase_q == 3'd0)
                        rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                end
                if (fin_en) begin
                    valid_q[slot_q]   <= 1'b1;
                    slot_klen[slot_q] <= klen_q;
                    busy              <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_SLOTS; s++)
                for (int w = 0; w < 60; w++) mem[s][w] <= '0;
        end else if (zero_req) begin
            for (int s = 0; s < NUM_SLOTS; s++)
                for (int w = 0; w < 60; w++) mem[s][w] <= '0;
        end else if (load_en) begin
            for (int m = 0; m < 8; m++)
                if (m < int'(nk)) mem[slot_q][m] <= kw[m];
        end else if (gen_en) begin
            mem[slot_q][widx_q] <= new_w;
        end
    end

    // Slot and word indices are clamped so the array is never addressed out of range.
    always_comb begin
        rd_in_range = int'(slot_rd) < NUM_SLOTS;
        rd_slot     = rd_in_range ? slot_rd : '0;
        ready       = rd_in_range && valid_q[rd_slot];
        rd_hit      = ready && (round <= nr_of(slot_klen[rd_slot]));
        rd_base     = (round <= 4'd14) ? {round, 2'b00} : 6'd0;
        round_key   = '0;
        if (rd_hit)
            round_key = {mem[rd_slot][rd_base],         mem[rd_slot][rd_base + 6'd1],
                         mem[rd_slot][rd_base + 6'd2],  mem[rd_slot][rd_base + 6'd3]};
    end

endmodule

// File: tb/tb_aes_key_bank.sv
// Scoreboard bench for aes_key_bank: FIPS-197-style reference expansion, random keys/slots/reads,
// known-answer vectors, reject/ignore/reset/zeroize cases.
module tb_aes_key_bank;

    localparam int NS = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [255:0]   key = '0;
    logic [1:0]     keylen = '0;
    logic [1:0]     slot_wr = '0;
    logic           init = 1'b0;
    logic [1:0]     slot_rd = '0;
    logic [3:0]     round = '0;
    logic [127:0]   round_key;
    logic           ready, busy, done, err;
    logic [NS-1:0]  slot_valid;
    logic           zeroize = 1'b0;
    logic [31:0]    sboxw, new_sboxw;

    always #5 clk = ~clk;

    aes_key_bank #(.NUM_SLOTS(NS)) dut (
        .clk(clk), .reset_n(reset_n), .key(key), .keylen(keylen), .slot_wr(slot_wr),
        .init(init), .slot_rd(slot_rd), .round(round), .round_key(round_key),
        .ready(ready), .busy(busy), .done(done), .err(err), .slot_valid(slot_valid),
        .zeroize(zeroize), .sboxw(sboxw), .new_sboxw(new_sboxw)
    );

    // S-box built from the GF(2^8) inverse and affine map.
    logic [7:0] sbox_tbl [256];
    assign new_sboxw = {sbox_tbl[sboxw[31:24]], sbox_tbl[sboxw[23:16]],
                        sbox_tbl[sboxw[15:8]],  sbox_tbl[sboxw[7:0]]};

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tbl[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_of(input int j);
        logic [7:0] r;
        r = 8'h01;
        for (int n = 1; n < j; n++) r = xt(r);
        return r;
    endfunction

    // Reference model state
    logic [31:0] m_w [NS][60];
    bit          m_valid [NS];
    int          m_klen [NS];
    bit          m_busy = 0;
    logic [31:0] p_w [60];
    int          p_slot, p_klen, p_done;

    task automatic expand_pending(input logic [255:0] kv, input int kl);
        int nk, total;
        logic [31:0] t;
        nk = 4 + 2*kl;
        total = 4*(nk + 7);
        for (int i = 0; i < 60; i++) p_w[i] = '0;
        for (int i = 0; i < nk; i++) p_w[i] = kv[255 - 32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = p_w[i-1];
            if (i % nk == 0) t = subword({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
            else if (nk > 6 && i % nk == 4) t = subword(t);
            p_w[i] = p_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] model_rk(input int s, input int r);
        if (!m_valid[s] || r > 10 + 2*m_klen[s]) return '0;
        return {m_w[s][4*r], m_w[s][4*r+1], m_w[s][4*r+2], m_w[s][4*r+3]};
    endfunction

    function automatic logic [NS-1:0] model_vld();
        logic [NS-1:0] v;
        for (int s = 0; s < NS; s++) v[s] = m_valid[s];
        return v;
    endfunction

    // Scoreboard
    typedef struct { logic [127:0] rk; logic rdy; logic bsy; logic [NS-1:0] vld; } rchk_t;
    typedef struct { bit is_err; int cyc; } ev_t;
    rchk_t rq [$];
    ev_t   evq [$];
    rchk_t mon_r;
    ev_t   mon_e;
    logic  rd_chk = 1'b0;
    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    task automatic chk_event(input bit is_err_now);
        if (evq.size() == 0) begin
            chk(is_err_now ? "unexpected_err" : "unexpected_done", 128'(1), 128'(0));
        end else begin
            mon_e = evq.pop_front();
            chk(is_err_now ? "err_kind" : "done_kind", 128'(is_err_now), 128'(mon_e.is_err));
            chk(is_err_now ? "err_cycle" : "done_cycle", 128'(cyc), 128'(mon_e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (rd_chk) begin
            if (rq.size() == 0) chk("read_queue_empty", 128'(1), 128'(0));
            else begin
                mon_r = rq.pop_front();
                chk("round_key", round_key, mon_r.rk);
                chk("ready", 128'(ready), 128'(mon_r.rdy));
                chk("busy", 128'(busy), 128'(mon_r.bsy));
                chk("slot_valid", 128'(slot_valid), 128'(mon_r.vld));
            end
        end
        if (done === 1'b1) chk_event(1'b0);
        if (err === 1'b1)  chk_event(1'b1);
    end

    // Stimulus
    task automatic tick();
        @(posedge clk); #1;
        init = 1'b0; rd_chk = 1'b0; zeroize = 1'b0;
        if (m_busy && cyc >= p_done) begin
            for (int i = 0; i < 60; i++) m_w[p_slot][i] = p_w[i];
            m_valid[p_slot] = 1;
            m_klen[p_slot]  = p_klen;
            m_busy = 0;
        end
    endtask

    task automatic push_read(input int s, input int r, input logic [127:0] exp);
        rchk_t e;
        slot_rd = s[1:0]; round = r[3:0]; rd_chk = 1'b1;
        e.rk = exp; e.rdy = m_valid[s]; e.bsy = m_busy; e.vld = model_vld();
        rq.push_back(e);
    endtask

    task automatic do_read(input int s, input int r);
        push_read(s, r, model_rk(s, r));
    endtask

    task automatic issue_init(input int s, input int kl, input logic [255:0] kv);
        slot_wr = s[1:0]; keylen = kl[1:0]; key = kv; init = 1'b1;
        if (m_busy) tick();
        else if (kl == 3) begin
            tick();
            evq.push_back('{1'b1, cyc});
        end else begin
            tick();
            expand_pending(kv, kl);
            p_slot = s; p_klen = kl; m_valid[s] = 0; m_busy = 1;
            p_done = cyc + 42 + 6*kl;
            evq.push_back('{1'b0, p_done});
        end
    endtask

    task automatic run_reading(input int focus);
        while (m_busy) begin
            if (focus >= 0 && $urandom_range(0, 3) != 0) do_read(focus, $urandom_range(0, 14));
            else do_read($urandom_range(0, NS-1), $urandom_range(0, 15));
            tick();
        end
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] k;
        build_sbox();
        for (int s = 0; s < NS; s++) begin m_valid[s] = 0; m_klen[s] = 0; end

        tick();
        do_read(0, 0); tick();
        do_read(3, 14); tick();
        reset_n = 1'b1;
        do_read(1, 0); tick();

        issue_init(0, 0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        run_reading(-1);
        push_read(0, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c); tick();
        push_read(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6); tick();
        push_read(0, 11, 128'h0); tick();

        issue_init(1, 1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
        run_reading(0);
        push_read(1, 12, 128'he98ba06f448c773c8ecc720401002202); tick();
        push_read(1, 13, 128'h0); tick();

        issue_init(2, 2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        run_reading(1);
        push_read(2, 14, 128'hfe4890d1e6188d0b046df344706c631e); tick();
        push_read(2, 15, 128'h0); tick();

        // Slot 3 expands while slot 0 is read; a second init mid-expansion must be dropped.
        issue_init(3, 0, rand_key());
        for (int c = 0; c < 10; c++) begin do_read(0, c); tick(); end
        issue_init(1, 2, rand_key());
        run_reading(0);
        do_read(3, 10); tick();
        do_read(1, 12); tick();

        issue_init(2, 3, rand_key());
        do_read(2, 14); tick();
        tick();

        zeroize = 1'b1;
        tick();
`ifdef AES_KEY_BANK_ZEROIZE_EN
        for (int s = 0; s < NS; s++) m_valid[s] = 0;
`endif
        for (int s = 0; s < NS; s++) begin do_read(s, 0); tick(); end
        push_read(2, 14, model_rk(2, 14)); tick();

        // Back-to-back random expansions, including illegal keylen.
        for (int n = 0; n < 8; n++) begin
            k = rand_key();
            issue_init($urandom_range(0, NS-1), $urandom_range(0, 3), k);
            run_reading(-1);
            for (int s = 0; s < NS; s++) begin do_read(s, $urandom_range(0, 15)); tick(); end
        end

        // Reset during GEN cycle 20 of an AES-256 expansion.
        issue_init(3, 2, rand_key());
        for (int c = 0; c < 21; c++) begin do_read($urandom_range(0, NS-1), $urandom_range(0, 14)); tick(); end
        reset_n = 1'b0;
        #1;
        for (int s = 0; s < NS; s++) m_valid[s] = 0;
        m_busy = 0;
        void'(evq.pop_back());
        do_read(0, 0); tick();
        do_read(3, 5); tick();
        reset_n = 1'b1;
        do_read(2, 1); tick();

        issue_init(1, 0, rand_key());
        run_reading(3);
        do_read(1, 10); tick();

        repeat (4) tick();
        while (evq.size() != 0) begin
            mon_e = evq.pop_front();
            chk("missing_event", 128'(0), 128'(mon_e.cyc));
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
